aes_inv_core: RTL and testbench

Iterative AES-128 inverse cipher (decryption) engine: the receive-side counterpart of the AES_CORE encryptor. It accepts a 128-bit ciphertext and the 128-bit cipher key on a start strobe, computes one inverse round per clock with an on-the-fly reverse key schedule, and presents the plaintext with a one-cycle `finished` pulse. It sits beside AES_CORE so that a block produced by AES_CORE can be recovered with the same key.

---
 rtl/aes_pkg.sv | 59 +++++
 rtl/aes_inv_core_if.sv | 11 +
 rtl/aes_inv_round.sv | 23 ++
 rtl/aes_inv_core.sv | 115 +++++++++++
 tb/tb_aes_inv_core.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: AES-128 tables, GF(2^8) helpers, key-schedule steps and shared types.
package aes_pkg;
   typedef logic [0:15][7:0] state_t;
   typedef enum logic [1:0] {IDLE, KEYEXP, ROUND, DONE} fsm_t;
   localparam logic [0:9][7:0] RCON = {8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
   localparam logic [0:255][7:0] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= x;
         x = xtime(x);
      end
      return p;
   endfunction

   function automatic logic [31:0] sub_rot(input logic [31:0] w);
      return {SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]], SBOX[w[31:24]]};
   endfunction

   function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] w0, w1, w2, w3;
      w0 = k[127:96] ^ sub_rot(k[31:0]) ^ {rc, 24'h0};
      w1 = k[95:64] ^ w0;
      w2 = k[63:32] ^ w1;
      w3 = k[31:0] ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   // Undo one schedule step: recover the previous round key from the next one.
   function automatic logic [127:0] inv_key_step(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] w3;
      w3 = k[31:0] ^ k[63:32];
      return {k[127:96] ^ sub_rot(w3) ^ {rc, 24'h0}, k[95:64] ^ k[127:96], k[63:32] ^ k[95:64], w3};
   endfunction
endpackage

// File: rtl/aes_inv_core_if.sv
// aes_inv_core_if: request/result bundle between a client and the AES inverse core.
interface aes_inv_core_if;
   logic         start;
   logic [127:0] data_in;
   logic [127:0] key;
   logic [127:0] data_out;
   logic         busy;
   logic         finished;
   modport master (output start, data_in, key, input data_out, busy, finished);
   modport slave (input start, data_in, key, output data_out, busy, finished);
endinterface

// File: rtl/aes_inv_round.sv
// aes_inv_round: one combinational AES inverse round; last skips InvMixColumns.
module aes_inv_round
   import aes_pkg::*;
(
   input  state_t s,
   input  state_t rk,
   input  logic   last,
   output state_t nxt
);
   state_t t, m;
   always_comb begin
      t = '0;
      m = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            t[4*c+r] = INV_SBOX[s[4*((c-r)&3)+r]] ^ rk[4*c+r];
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            m[4*c+r] = gmul(8'h0e, t[4*c+r]) ^ gmul(8'h0b, t[4*c+((r+1)&3)]) ^
                       gmul(8'h0d, t[4*c+((r+2)&3)]) ^ gmul(8'h09, t[4*c+((r+3)&3)]);
   end
   assign nxt = last ? t : m;
endmodule

// File: rtl/aes_inv_core.sv
// aes_inv_core: iterative AES-128 decryptor, one inverse round per clock.
// Optional last-key w10 cache enabled by AES_INV_KEY_CACHE_EN.
module aes_inv_core
   import aes_pkg::*;
(
   input logic          clk,
   input logic          rst_n,
   aes_inv_core_if.slave bus
);
   fsm_t         st_q, st_d;
   logic [3:0]   cnt_q, cnt_d;
   logic [127:0] rk_q, rk_d, data_q, data_d, out_q, out_d, rk_rnd;
   state_t       s_q, s_d, rnd_out;
   logic         busy_q, busy_d, fin_q, fin_d;
`ifdef AES_INV_KEY_CACHE_EN
   logic [127:0] kc_q, kc_d, wc_q, wc_d;
   logic         cv_q, cv_d;
`endif

   // cnt counts up through the schedule and down through the rounds
   assign rk_rnd = inv_key_step(rk_q, RCON[cnt_q]);

   aes_inv_round u_round (.s(s_q), .rk(rk_rnd), .last(cnt_q == 4'd0), .nxt(rnd_out));

   always_comb begin
      st_d   = st_q;
      cnt_d  = cnt_q;
      rk_d   = rk_q;
      s_d    = s_q;
      data_d = data_q;
      out_d  = out_q;
`ifdef AES_INV_KEY_CACHE_EN
      kc_d   = kc_q;
      wc_d   = wc_q;
      cv_d   = cv_q;
`endif
      case (st_q)
         IDLE: if (bus.start) begin
            data_d = bus.data_in;
            rk_d   = bus.key;
            cnt_d  = 4'd0;
            st_d   = KEYEXP;
`ifdef AES_INV_KEY_CACHE_EN
            if (cv_q && bus.key == kc_q) begin
               s_d   = bus.data_in ^ wc_q;
               rk_d  = wc_q;
               cnt_d = 4'd9;
               st_d  = ROUND;
            end else begin
               kc_d = bus.key;
               cv_d = 1'b0;
            end
`endif
         end
         KEYEXP: begin
            rk_d  = key_step(rk_q, RCON[cnt_q]);
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd9) begin
               s_d   = data_q ^ rk_d;
               cnt_d = 4'd9;
               st_d  = ROUND;
`ifdef AES_INV_KEY_CACHE_EN
               wc_d  = rk_d;
               cv_d  = 1'b1;
`endif
            end
         end
         ROUND: begin
            rk_d  = rk_rnd;
            s_d   = rnd_out;
            cnt_d = cnt_q - 4'd1;
            out_d = cnt_q == 4'd0 ? rnd_out : out_q;
            st_d  = cnt_q == 4'd0 ? DONE : ROUND;
         end
         DONE: st_d = IDLE;
      endcase
      busy_d = st_d != IDLE;
      fin_d  = st_d == DONE;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         st_q   <= IDLE;
         cnt_q  <= '0;
         rk_q   <= '0;
         s_q    <= '0;
         data_q <= '0;
         out_q  <= '0;
         busy_q <= 1'b0;
         fin_q  <= 1'b0;
`ifdef AES_INV_KEY_CACHE_EN
         kc_q   <= '0;
         wc_q   <= '0;
         cv_q   <= 1'b0;
`endif
      end else begin
         st_q   <= st_d;
         cnt_q  <= cnt_d;
         rk_q   <= rk_d;
         s_q    <= s_d;
         data_q <= data_d;
         out_q  <= out_d;
         busy_q <= busy_d;
         fin_q  <= fin_d;
`ifdef AES_INV_KEY_CACHE_EN
         kc_q   <= kc_d;
         wc_q   <= wc_d;
         cv_q   <= cv_d;
`endif
      end

   assign bus.data_out = out_q;
   assign bus.busy     = busy_q;
   assign bus.finished = fin_q;
endmodule

// File: tb/tb_aes_inv_core.sv
// tb_aes_inv_core: checks aes_inv_core against FIPS-197 vectors and a forward AES model.
module tb_aes_inv_core;
`ifdef AES_INV_KEY_CACHE_EN
   localparam bit CACHE = 1'b1;
`else
   localparam bit CACHE = 1'b0;
`endif
   logic clk = 0, rst_n = 0;
   int checks = 0, errors = 0;
   logic [7:0] sbt [256];
   logic cvalid = 0;
   logic [127:0] ckey = '0;

   aes_inv_core_if bus ();
   aes_inv_core dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   typedef struct {logic [127:0] ct; logic [127:0] key; logic [127:0] pt;} vec_t;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = '0;
      for (int i = 0; i < 8; i++) if (b[i]) p ^= 16'(a) << i;
      for (int i = 15; i >= 8; i--) if (p[i]) p ^= 16'h11b << (i - 8);
      return p[7:0];
   endfunction

   function automatic logic [127:0] enc(input logic [127:0] pt, input logic [127:0] k);
      logic [7:0] st [16], tmp [16];
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0] rc;
      logic [127:0] res;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {sbt[t[23:16]], sbt[t[15:8]], sbt[t[7:0]], sbt[t[31:24]]} ^ {rc, 24'h0};
            rc = gm(rc, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int i = 0; i < 16; i++) st[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
      for (int r = 1; r <= 10; r++) begin
         for (int i = 0; i < 16; i++) tmp[i] = sbt[st[4*((i/4 + i%4) % 4) + i%4]];
         for (int c = 0; c < 4; c++)
            for (int j = 0; j < 4; j++)
               st[4*c+j] = (r < 10 ? gm(8'h02, tmp[4*c+j]) ^ gm(8'h03, tmp[4*c+(j+1)%4]) ^
                            tmp[4*c+(j+2)%4] ^ tmp[4*c+(j+3)%4] : tmp[4*c+j]) ^ w[4*r+c][31-8*j -: 8];
      end
      for (int i = 0; i < 16; i++) res[127-8*i -: 8] = st[i];
      return res;
   endfunction

   function automatic int lat_exp(input logic [127:0] k);
      return (CACHE && cvalid && k == ckey) ? 10 : 20;
   endfunction

   task automatic note(input logic [127:0] k);
      cvalid = 1;
      ckey = k;
   endtask

   task automatic wait_idle();
      @(negedge clk);
      for (int n = 0; n < 100 && bus.busy; n++) @(negedge clk);
   endtask

   task automatic op(input logic [127:0] d, input logic [127:0] k, output logic [127:0] r, output int lat);
      wait_idle();
      bus.data_in = d;
      bus.key = k;
      bus.start = 1;
      @(posedge clk);
      #1 bus.start = 0;
      chk("busy_after_accept", bus.busy, 1);
      lat = -1;
      for (int n = 1; n <= 60; n++) begin
         @(posedge clk);
         #1;
         if (bus.finished) begin
            lat = n;
            break;
         end
      end
      r = bus.data_out;
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      vec_t tbl [5];
      logic [127:0] r, k, pt, ct, kA, kX, pA, pX;
      logic [7:0] inv;
      int lat, el, el2;
      int p [$];
      logic [127:0] res [$];
      for (int x = 0; x < 256; x++) begin
         inv = 0;
         for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sbt[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      end
      tbl[0] = '{128'h3925841d02dc09fbdc118597196a0b32, 128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734};
      tbl[1] = '{128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff};
      tbl[2] = tbl[1];
      tbl[3] = tbl[0];
      tbl[4] = tbl[0];
      bus.start = 0;
      bus.data_in = '0;
      bus.key = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_data_out", bus.data_out, 0);
      chk("reset_busy", bus.busy, 0);
      chk("reset_finished", bus.finished, 0);
      @(negedge clk) rst_n = 1;

      for (int i = 0; i < 5; i++) begin
         el = lat_exp(tbl[i].key);
         op(tbl[i].ct, tbl[i].key, r, lat);
         chk($sformatf("vec%0d_data", i), r, tbl[i].pt);
         chk($sformatf("vec%0d_latency", i), lat, el);
         note(tbl[i].key);
      end

      // start held high through busy and DONE, inputs changed after acceptance
      kA = rnd128(); pA = rnd128();
      kX = rnd128(); pX = rnd128();
      el = lat_exp(kA);
      wait_idle();
      bus.data_in = enc(pA, kA);
      bus.key = kA;
      bus.start = 1;
      @(posedge clk);
      #1;
      bus.data_in = enc(pX, kX);
      bus.key = kX;
      for (int n = 1; n <= 100; n++) begin
         @(posedge clk);
         #1;
         if (bus.finished) begin
            p.push_back(n);
            res.push_back(bus.data_out);
         end
         if (p.size() == 2) break;
      end
      bus.start = 0;
      if (p.size() != 2) chk("hold_two_pulses", p.size(), 2);
      else begin
         note(kA);
         el2 = 2 + lat_exp(kX);
         note(kX);
         chk("hold_first_latency", p[0], el);
         chk("hold_first_data", res[0], pA);
         chk("hold_gap", p[1] - p[0], el2);
         chk("hold_second_data", res[1], pX);
      end

      // reset in the middle of an operation
      wait_idle();
      bus.data_in = rnd128();
      bus.key = kX;
      bus.start = 1;
      @(posedge clk);
      #1 bus.start = 0;
      repeat (8) @(posedge clk);
      #3 rst_n = 0;
      #1;
      chk("midreset_data_out", bus.data_out, 0);
      chk("midreset_busy", bus.busy, 0);
      chk("midreset_finished", bus.finished, 0);
      cvalid = 0;
      @(negedge clk) rst_n = 1;
      pt = rnd128();
      op(enc(pt, kX), kX, r, lat);
      chk("post_reset_data", r, pt);
      chk("post_reset_latency", lat, 20);
      note(kX);

      k = rnd128();
      for (int i = 0; i < 50; i++) begin
         if (i % 3 == 0) k = rnd128();
         pt = rnd128();
         ct = enc(pt, k);
         el = lat_exp(k);
         op(ct, k, r, lat);
         chk($sformatf("rt%0d_data", i), r, pt);
         chk($sformatf("rt%0d_latency", i), lat, el);
         note(k);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end
endmodule
